// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared control encodings for the hazard controller: IF_ID/ID_EX control
// values and the mult/div tracker state type.
package pipe_hazard_ctrl_pkg;

    localparam logic IF_ID_WRITE_ON  = 1'b1;
    localparam logic IF_ID_WRITE_OFF = 1'b0;
    localparam logic IF_ID_FLUSH_ON  = 1'b1;
    localparam logic IF_ID_FLUSH_OFF = 1'b0;
    localparam logic ID_EX_FLUSH_ON  = 1'b1;
    localparam logic ID_EX_FLUSH_OFF = 1'b0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Tracks one in-flight mult/div: busy for exactly MD_LATENCY cycles after an
// accepted start.
module md_busy_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = MD_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, mult/div and fetch-wait stalls plus
// ID redirects. Optional perf counters under macro HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic       id_branch_taken,
    input  logic       id_md_start,
    input  logic       id_md_read,
    input  logic       imem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    logic lu, md_stall, stall, redirect;

    assign lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
    assign md_stall = md_busy && (id_md_start || id_md_read);
    assign stall    = lu || md_stall;
    assign redirect = id_branch_taken && !stall;

    // A start is only accepted when the issuing instruction is not itself held.
    md_busy_tracker #(
        .MD_LATENCY(MD_LATENCY),
        .CNT_W     (CNT_W)
    ) u_md_busy_tracker (
        .clk  (clk),
        .reset(reset),
        .start(id_md_start && !stall),
        .busy (md_busy)
    );

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = IF_ID_WRITE_ON;
        if_id_flush = IF_ID_FLUSH_OFF;
        id_ex_flush = ID_EX_FLUSH_OFF;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = IF_ID_WRITE_OFF;
            if_id_flush = IF_ID_FLUSH_OFF;
            id_ex_flush = ID_EX_FLUSH_OFF;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = IF_ID_WRITE_OFF;
            id_ex_flush = ID_EX_FLUSH_ON;
        end else if (redirect) begin
            if_id_flush = IF_ID_FLUSH_ON;
        end else if (!imem_ready) begin
            // Fetch wait: bubble into ID so the current ID instruction is not re-issued.
            pc_write    = 1'b0;
            if_id_write = IF_ID_WRITE_OFF;
            if_id_flush = IF_ID_FLUSH_ON;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if ((if_id_flush == IF_ID_FLUSH_ON) && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline hazard controller that drives the stall/flush side of the IF/ID register, plus the PC enable and an ID/EX bubble.
- Detects load-use hazards, mult/div structural hazards and instruction-fetch wait states, and resolves ID-stage control-flow redirects.
- Owns a small FSM and latency counter that track an in-flight multi-cycle mult/div operation.
- Sits beside the ID stage; its outputs feed the PC register, IF_ID and ID_EX.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue; legal range 1..255.
- CNT_W, 8, width of the latency counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination register of the load in EX
- id_branch_taken  in  1  branch or jump in ID resolved taken
- id_md_start  in  1  instruction in ID issues mult/div
- id_md_read  in  1  instruction in ID is mfhi/mflo
- imem_ready  in  1  instruction memory has valid data this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF_ID write enable; uses `IF_ID_WRITE_ON / `IF_ID_WRITE_OFF
- if_id_flush  out  1  IF_ID flush; uses `IF_ID_FLUSH_ON / `IF_ID_FLUSH_OFF
- id_ex_flush  out  1  insert a bubble into ID_EX
- md_busy  out  1  mult/div in flight

Behaviour:
- Terms (all combinational):
  - lu = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==id_rs || (id_uses_rt && id_ex_rt==id_rt)).
  - md_stall = md_busy && (id_md_start || id_md_read).
  - stall = lu || md_stall.
  - redirect = id_branch_taken && !stall.
- Output priority, evaluated in order; outputs are combinational from the FSM state and the inputs:
  1. reset high: all outputs 0.
  2. stall: pc_write=0, if_id_write=OFF, if_id_flush=OFF, id_ex_flush=1. The IF_ID contents are held and a bubble enters EX.
  3. redirect: pc_write=1, if_id_write=ON, if_id_flush=ON, id_ex_flush=0.
  4. !imem_ready: pc_write=0, if_id_write=OFF, if_id_flush=ON, id_ex_flush=0. A bubble enters ID, so the current ID instruction is never duplicated.
  5. Otherwise: pc_write=1, if_id_write=ON, if_id_flush=OFF, id_ex_flush=0.
- MD FSM:
  - States are IDLE and BUSY. On reset: IDLE, cnt=0, md_busy=0.
  - IDLE: if id_md_start && !stall, load cnt=MD_LATENCY-1 and go to BUSY next edge.
  - BUSY: if cnt==0, go to IDLE; otherwise cnt decrements.
  - md_busy = (state==BUSY).
- Boundaries:
  - MD_LATENCY=1 gives exactly one BUSY cycle.
  - id_md_start on the last BUSY cycle (cnt==0) still stalls for that cycle, then issues from IDLE on the next cycle.
  - A load-use hazard and a redirect in the same cycle: the stall wins and the redirect is re-evaluated next cycle.
  - Redirect while imem_ready=0: the redirect wins.
  - Reset asserted mid-BUSY aborts to IDLE immediately.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flushes[31:0], both reset to 0.
  - perf_stall_cycles increments on every cycle with stall=1.
  - perf_flushes increments on every cycle with if_id_flush=ON.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- ctrl_encode_def.v is the shared package. It holds:
  - the existing `IF_ID_WRITE_ON/OFF and `IF_ID_FLUSH_ON/OFF encodings;
  - new `ID_EX_FLUSH_ON/OFF encodings;
  - MD FSM state encodings `MD_IDLE=1'b0 and `MD_BUSY=1'b1.
- One sub-module is natural: md_busy_tracker, containing the FSM and counter with inputs start/reset/clk and output busy.
- Hazard decode and output priority stay in the top-level module.

Test Plan:
- id_ex_mem_read=1, id_ex_rt=5, id_rs=5 -> pc_write=0, if_id_write=OFF, id_ex_flush=1 for that cycle; with id_ex_rt=0 instead -> no stall.
- id_ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall; set id_uses_rt=1 -> stall.
- id_branch_taken=1, imem_ready=1, no hazard -> pc_write=1, if_id_flush=ON; the same inputs with lu=1 -> stall outputs and if_id_flush=OFF.
- MD_LATENCY=4, id_md_start pulse -> md_busy high for exactly 4 cycles; id_md_read during those cycles -> stall every cycle; on the 5th cycle -> no stall.
- imem_ready=0 for 3 cycles -> pc_write=0 and if_id_flush=ON for all 3; a redirect during the 2nd cycle -> pc_write=1 in that cycle.
- Reset asserted in the 2nd BUSY cycle -> md_busy=0 immediately and all outputs 0; after release, the FSM is IDLE.
